// File: rtl/gte_microcode_sequencer_pkg.sv
// gte_microcode_sequencer_pkg
// Shared definitions for the GTE microcode sequencer: sequencer state enum,
// GTE opcode constants and the opcode -> microcode start-PC table.
// The start-PC table is generated together with the microcode ROM image, so
// every non-zero entry points at the first word of that opcode's routine.
// An entry of 0 marks an unimplemented opcode (ROM word 0 is the NOP).
package gte_microcode_sequencer_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [8:0] upc_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } seq_state_t;

  localparam opcode_t GTE_OP_RTPS  = 6'h01;
  localparam opcode_t GTE_OP_NCLIP = 6'h06;
  localparam opcode_t GTE_OP_OP    = 6'h0C;
  localparam opcode_t GTE_OP_DPCS  = 6'h10;
  localparam opcode_t GTE_OP_MVMVA = 6'h12;
  localparam opcode_t GTE_OP_CDP   = 6'h14;
  localparam opcode_t GTE_OP_NCDT  = 6'h16;
  localparam opcode_t GTE_OP_NCS   = 6'h1E;
  localparam opcode_t GTE_OP_SQR   = 6'h28;
  localparam opcode_t GTE_OP_AVSZ3 = 6'h2D;
  localparam opcode_t GTE_OP_RTPT  = 6'h30;
  localparam opcode_t GTE_OP_GPL   = 6'h3E;

  function automatic upc_t gte_start_pc(opcode_t op);
    upc_t pc;
    case (op)
      GTE_OP_RTPS:  pc = 9'h010;
      GTE_OP_NCLIP: pc = 9'h020;
      GTE_OP_OP:    pc = 9'h028;
      GTE_OP_DPCS:  pc = 9'h030;
      GTE_OP_MVMVA: pc = 9'h040;
      GTE_OP_CDP:   pc = 9'h050;
      GTE_OP_NCDT:  pc = 9'h060;
      GTE_OP_NCS:   pc = 9'h110;
      GTE_OP_SQR:   pc = 9'h120;
      GTE_OP_AVSZ3: pc = 9'h138;
      GTE_OP_RTPT:  pc = 9'h148;
      GTE_OP_GPL:   pc = 9'h1F8;
      default:      pc = '0;
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/gte_microcode_sequencer_if.sv
// gte_microcode_sequencer_if
// Command / microcode-ROM bundle between the CPU-side command port, the
// datapath and the sequencer.
//   i_run, i_instr   : command request and opcode
//   o_ready          : sequencer can take a command this cycle
//   i_stall          : datapath hold request
//   i_lastInstr      : lastInstr flag of the ROM word at o_PC
//   o_PC             : microcode ROM address
//   o_isNewInstr     : first step of a command
//   o_instr          : opcode of the running command
//   o_busy           : a command is executing
//   o_done/o_illegal/o_timeout : one-cycle completion pulses
// master = command/datapath side, slave = sequencer.
interface gte_microcode_sequencer_if;
  import gte_microcode_sequencer_pkg::*;

  logic    i_run;
  opcode_t i_instr;
  logic    o_ready;
  logic    i_stall;
  logic    i_lastInstr;
  upc_t    o_PC;
  logic    o_isNewInstr;
  opcode_t o_instr;
  logic    o_busy;
  logic    o_done;
  logic    o_illegal;
  logic    o_timeout;

  modport master (
    output i_run, i_instr, i_stall, i_lastInstr,
    input  o_ready, o_PC, o_isNewInstr, o_instr, o_busy, o_done, o_illegal, o_timeout
  );

  modport slave (
    input  i_run, i_instr, i_stall, i_lastInstr,
    output o_ready, o_PC, o_isNewInstr, o_instr, o_busy, o_done, o_illegal, o_timeout
  );

endinterface

// File: rtl/gte_microcode_sequencer_start_pc_rom.sv
// gte_start_pc_rom
// Combinational opcode -> microcode start-PC lookup.
//   i_op       : 6-bit GTE opcode
//   o_start_pc : 9-bit start address, 0 for an unimplemented opcode
module gte_start_pc_rom
  import gte_microcode_sequencer_pkg::*;
(
  input  opcode_t i_op,
  output upc_t    o_start_pc
);

  always_comb begin
    o_start_pc = gte_start_pc(i_op);
  end

endmodule

// File: rtl/gte_microcode_sequencer.sv
// gte_microcode_sequencer
// Drives the GTE microcode ROM program counter. A command is looked up in the
// start-PC table, then the PC steps once per non-stalled cycle until the ROM
// flags the last word. A one-deep pending slot lets the next command queue up
// behind the running one; a step-count watchdog aborts runaway routines.
//   i_clk : clock
//   i_rst : asynchronous active-high reset
//   bus   : command / ROM bundle (slave side)
// Parameter WATCHDOG_MAX (2..511): step limit per command before abort.
module gte_microcode_sequencer
  import gte_microcode_sequencer_pkg::*;
#(
  parameter int unsigned WATCHDOG_MAX = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  gte_microcode_sequencer_if.slave   bus
);

  seq_state_t state_q, state_d;
  upc_t       pc_q, pc_d;
  logic       is_new_q, is_new_d;
  opcode_t    instr_q, instr_d;
  logic       pend_valid_q, pend_valid_d;
  opcode_t    pend_instr_q, pend_instr_d;
  logic [8:0] step_q, step_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;

  logic       ready;
  logic       accept;
  logic       finish;
  opcode_t    lookup_op;
  upc_t       start_pc;

  // While running, a queued command has priority for the lookup; otherwise
  // the incoming opcode is looked up (this covers the completion bypass).
  always_comb begin
    lookup_op = (state_q == ST_RUN && pend_valid_q) ? pend_instr_q : bus.i_instr;
  end

  gte_start_pc_rom u_start_pc_rom (
    .i_op       (lookup_op),
    .o_start_pc (start_pc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      is_new_q     <= 1'b0;
      instr_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_instr_q <= '0;
      step_q       <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      is_new_q     <= is_new_d;
      instr_q      <= instr_d;
      pend_valid_q <= pend_valid_d;
      pend_instr_q <= pend_instr_d;
      step_q       <= step_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    is_new_d     = is_new_q;
    instr_d      = instr_q;
    pend_valid_d = pend_valid_q;
    pend_instr_d = pend_instr_q;
    step_d       = step_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    timeout_d    = 1'b0;
    finish       = 1'b0;
    accept       = bus.i_run && ready;

    unique case (state_q)
      ST_IDLE: begin
        // A slot occupied in IDLE can only hold an illegal opcode left behind
        // by the previous command; it retires here, one cycle after that
        // command's own done pulse.
        if (pend_valid_q) begin
          done_d       = 1'b1;
          illegal_d    = 1'b1;
          pend_valid_d = 1'b0;
        end
        if (accept) begin
          if (start_pc != '0) begin
            state_d  = ST_RUN;
            pc_d     = start_pc;
            is_new_d = 1'b1;
            instr_d  = bus.i_instr;
            step_d   = '0;
          end else if (pend_valid_q) begin
            // Retirement pulse already claimed this cycle: queue behind it.
            pend_valid_d = 1'b1;
            pend_instr_d = bus.i_instr;
          end else begin
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          pend_valid_d = 1'b1;
          pend_instr_d = bus.i_instr;
        end
        if (!bus.i_stall) begin
          finish = bus.i_lastInstr || (step_q + 9'd1 == 9'(WATCHDOG_MAX));
          if (!finish) begin
            pc_d     = pc_q + 9'd1;
            is_new_d = 1'b0;
            step_d   = step_q + 9'd1;
          end else begin
            done_d    = 1'b1;
            timeout_d = !bus.i_lastInstr;
            state_d   = ST_IDLE;
            pc_d      = '0;
            is_new_d  = 1'b0;
            // Successor is either the slot or a same-cycle accept (bypass).
            // An illegal successor stays in the slot and retires from IDLE.
            if ((pend_valid_q || accept) && start_pc != '0) begin
              state_d      = ST_RUN;
              pc_d         = start_pc;
              is_new_d     = 1'b1;
              instr_d      = lookup_op;
              step_d       = '0;
              pend_valid_d = 1'b0;
            end
          end
        end
      end

      default: ;
    endcase
  end

  always_comb begin
    ready            = (state_q == ST_IDLE) || !pend_valid_q;
    bus.o_ready      = ready;
    bus.o_busy       = (state_q == ST_RUN);
    bus.o_PC         = pc_q;
    bus.o_isNewInstr = is_new_q;
    bus.o_instr      = instr_q;
    bus.o_done       = done_q;
    bus.o_illegal    = illegal_q;
    bus.o_timeout    = timeout_q;
  end

endmodule
